// File: rtl/flappy_pkg.sv
// Shared definitions for the flappy game blocks: geometry defaults,
// one-hot state encodings and small helpers used by the pipe, bird and
// collision/score logic.
package flappy_pkg;

    // Geometry defaults, all in pixels
    localparam int BIRD_X_DEF   = 200;
    localparam int BIRD_W_DEF   = 20;
    localparam int BIRD_H_DEF   = 20;
    localparam int PIPE_W_DEF   = 60;
    localparam int GAP_H_DEF    = 120;
    localparam int FLOOR_Y_DEF  = 470;
    localparam int SCREEN_W_DEF = 800;

    // Score saturation value, 4-digit BCD
    localparam logic [15:0] BCD_MAX = 16'h9999;

    // Game states, one-hot
    typedef enum logic [2:0] {
        ST_IDLE = 3'b001,
        ST_PLAY = 3'b010,
        ST_LOST = 3'b100
    } game_state_e;

    // Result of comparing one pipe against the bird box
    typedef struct packed {
        logic hit;        // bird box outside the gap while overlapping in X
        logic pass_set;   // pipe right edge fully left of the bird
        logic pass_clr;   // pipe back at/right of the bird, or offscreen
    } pipe_eval_t;

    // Add 0..2 to a 4-digit BCD value, clamping at 9999 on overflow
    function automatic logic [15:0] bcd_add_sat(input logic [15:0] val,
                                                input logic [1:0]  amt);
        logic [15:0] res;
        logic [4:0]  sum;
        logic [1:0]  carry;
        res   = val;
        carry = amt;
        for (int i = 0; i < 4; i++) begin
            sum = {1'b0, val[i*4 +: 4]} + {3'b000, carry};
            if (sum > 5'd9) begin
                res[i*4 +: 4] = 4'(sum - 5'd10);
                carry         = 2'd1;
            end else begin
                res[i*4 +: 4] = sum[3:0];
                carry         = 2'd0;
            end
        end
        if (carry != 2'd0) begin
            res = BCD_MAX;
        end
        return res;
    endfunction

endpackage

// File: rtl/bcd_counter4.sv
// Four-digit BCD score counter. Counts up by one or two per cycle
// (two pipes can be passed together) and sticks at 9999.
module bcd_counter4
    import flappy_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset,
    input  logic        inc1,
    input  logic        inc2,
    input  logic        clr,
    output logic [15:0] count
);

    logic [15:0] count_q;
    logic [15:0] count_d;
    logic [1:0]  amt;

    // Next count: clear wins over increment
    always_comb begin
        amt     = {1'b0, inc1} + {1'b0, inc2};
        count_d = count_q;
        if (clr) begin
            count_d = 16'h0000;
        end else if (amt != 2'd0) begin
            count_d = bcd_add_sat(count_q, amt);
        end
    end

    // Count register with synchronous reset
    always_ff @(posedge Clk) begin
        if (Reset) begin
            count_q <= 16'h0000;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/collision_scorer.sv
// Collision detection, pass scoring and game-state control for the flappy
// game. Compares the fixed-X bird box against two pipes and the screen
// boundaries, counts passed pipes in BCD and keeps a high score.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for a Start edge; score and pass flags frozen
// PLAY  | game running; hits and passes evaluated every cycle
// LOST  | game over; Lost high, waiting for a Start edge back to IDLE
module collision_scorer
    import flappy_pkg::*;
#(
    parameter int BIRD_X   = BIRD_X_DEF,
    parameter int BIRD_W   = BIRD_W_DEF,
    parameter int BIRD_H   = BIRD_H_DEF,
    parameter int PIPE_W   = PIPE_W_DEF,
    parameter int GAP_H    = GAP_H_DEF,
    parameter int FLOOR_Y  = FLOOR_Y_DEF,
    parameter int SCREEN_W = SCREEN_W_DEF
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic [9:0]  BirdPosY,
    input  logic [9:0]  PipePosX1,
    input  logic [9:0]  PipePosY1,
    input  logic [9:0]  PipePosX2,
    input  logic [9:0]  PipePosY2,
    output logic        Lost,
    output logic [15:0] Score,
    output logic [15:0] HighScore,
    output logic        Playing
);

    // 11-bit geometry so that position + size never wraps
    localparam logic [10:0] BIRD_L11  = 11'(BIRD_X);
    localparam logic [10:0] BIRD_R11  = 11'(BIRD_X + BIRD_W);
    localparam logic [10:0] BIRD_H11  = 11'(BIRD_H);
    localparam logic [10:0] PIPE_W11  = 11'(PIPE_W);
    localparam logic [10:0] GAP_H11   = 11'(GAP_H);
    localparam logic [10:0] FLOOR_11  = 11'(FLOOR_Y);
    localparam logic [10:0] SCREEN_11 = 11'(SCREEN_W);

    // Compare one pipe against the bird box
    function automatic pipe_eval_t pipe_eval(input logic [9:0] px,
                                             input logic [9:0] py,
                                             input logic [9:0] by);
        pipe_eval_t  r;
        logic [10:0] x;
        logic [10:0] y;
        logic [10:0] b;
        logic        active;
        logic        x_overlap;
        x         = {1'b0, px};
        y         = {1'b0, py};
        b         = {1'b0, by};
        active    = (x < SCREEN_11);
        x_overlap = (x < BIRD_R11) && ((x + PIPE_W11) > BIRD_L11);
        r.hit      = active && x_overlap &&
                     ((b < y) || ((b + BIRD_H11) > (y + GAP_H11)));
        r.pass_set = active && ((x + PIPE_W11) < BIRD_L11);
        r.pass_clr = !active || (x >= BIRD_R11);
        return r;
    endfunction

    game_state_e state_q, state_d;
    logic        start_prev_q, start_prev_d;
    logic [1:0]  passed_q, passed_d;
    logic        lost_q, lost_d;
    logic        playing_q, playing_d;
    logic        lost_entry_q, lost_entry_d;
    logic [15:0] high_score_q, high_score_d;

    pipe_eval_t  pipe1_ev;
    pipe_eval_t  pipe2_ev;
    logic        boundary_hit;
    logic        hit;
    logic        start_rise;
    logic        in_play;
    logic [1:0]  pass_inc;
    logic        score_clr;
    logic [15:0] score;

    // Geometry comparators
    always_comb begin
        pipe1_ev     = pipe_eval(PipePosX1, PipePosY1, BirdPosY);
        pipe2_ev     = pipe_eval(PipePosX2, PipePosY2, BirdPosY);
        boundary_hit = (BirdPosY == 10'd0) ||
                       (({1'b0, BirdPosY} + BIRD_H11) >= FLOOR_11);
    end

    // Next-state, pass flags, score control and registered outputs
    always_comb begin
        start_rise   = Start && !start_prev_q;
        start_prev_d = Start;
        in_play      = (state_q == ST_PLAY);
        hit          = in_play && (pipe1_ev.hit || pipe2_ev.hit || boundary_hit);

        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start_rise) state_d = ST_PLAY;
            ST_PLAY: if (hit)        state_d = ST_LOST;
            ST_LOST: if (start_rise) state_d = ST_IDLE;
            default:                 state_d = ST_IDLE;
        endcase

        // A pass scores only on the flag's 0->1 transition, so a pipe
        // parked left of the bird counts once.
        passed_d = passed_q;
        pass_inc = 2'b00;
        if (in_play) begin
            if (pipe1_ev.pass_clr) begin
                passed_d[0] = 1'b0;
            end else if (pipe1_ev.pass_set) begin
                passed_d[0] = 1'b1;
                pass_inc[0] = !passed_q[0];
            end
            if (pipe2_ev.pass_clr) begin
                passed_d[1] = 1'b0;
            end else if (pipe2_ev.pass_set) begin
                passed_d[1] = 1'b1;
                pass_inc[1] = !passed_q[1];
            end
        end

        score_clr = (state_q == ST_IDLE) && start_rise;

        lost_d       = (state_d == ST_LOST);
        playing_d    = (state_d == ST_PLAY);
        lost_entry_d = hit;

        // Score already includes any pass from the hit cycle by now
        high_score_d = high_score_q;
        if (lost_entry_q && (score > high_score_q)) begin
            high_score_d = score;
        end
    end

    // State, flags and outputs with synchronous reset
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= ST_IDLE;
            start_prev_q <= 1'b0;
            passed_q     <= 2'b00;
            lost_q       <= 1'b0;
            playing_q    <= 1'b0;
            lost_entry_q <= 1'b0;
            high_score_q <= 16'h0000;
        end else begin
            state_q      <= state_d;
            start_prev_q <= start_prev_d;
            passed_q     <= passed_d;
            lost_q       <= lost_d;
            playing_q    <= playing_d;
            lost_entry_q <= lost_entry_d;
            high_score_q <= high_score_d;
        end
    end

    bcd_counter4 u_score (
        .Clk   (Clk),
        .Reset (Reset),
        .inc1  (pass_inc[0]),
        .inc2  (pass_inc[1]),
        .clr   (score_clr),
        .count (score)
    );

    assign Lost      = lost_q;
    assign Playing   = playing_q;
    assign Score     = score;
    assign HighScore = high_score_q;

endmodule

// File: tb/tb_collision_scorer.sv
// Directed bench for collision_scorer: a table of single-cycle geometry
// vectors played from a fresh game, plus sequences for pass counting,
// high score, Start-edge handling, reset abort and saturation.
module tb_collision_scorer;

    logic        Clk;
    logic        Reset;
    logic        Start;
    logic [9:0]  BirdPosY;
    logic [9:0]  PipePosX1;
    logic [9:0]  PipePosY1;
    logic [9:0]  PipePosX2;
    logic [9:0]  PipePosY2;
    logic        Lost;
    logic [15:0] Score;
    logic [15:0] HighScore;
    logic        Playing;

    int total = 0;
    int bad   = 0;

    collision_scorer dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Start     (Start),
        .BirdPosY  (BirdPosY),
        .PipePosX1 (PipePosX1),
        .PipePosY1 (PipePosY1),
        .PipePosX2 (PipePosX2),
        .PipePosY2 (PipePosY2),
        .Lost      (Lost),
        .Score     (Score),
        .HighScore (HighScore),
        .Playing   (Playing)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        string       name;
        logic [9:0]  by;
        logic [9:0]  px1;
        logic [9:0]  py1;
        logic [9:0]  px2;
        logic [9:0]  py2;
        logic        exp_lost;
        logic [15:0] exp_score;
    } vec_t;

    localparam int NVEC = 19;
    vec_t vecs [NVEC];

    function automatic vec_t mk(input string n, input int by, input int px1,
                                input int py1, input int px2, input int py2,
                                input logic el, input logic [15:0] es);
        vec_t v;
        v.name = n;
        v.by = 10'(by); v.px1 = 10'(px1); v.py1 = 10'(py1);
        v.px2 = 10'(px2); v.py2 = 10'(py2);
        v.exp_lost = el; v.exp_score = es;
        return v;
    endfunction

    // All driving and sampling happens at the falling edge
    task automatic tick();
        @(negedge Clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic safe();
        BirdPosY  = 10'd200;
        PipePosX1 = 10'd1000;
        PipePosY1 = 10'd150;
        PipePosX2 = 10'd1000;
        PipePosY2 = 10'd150;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        Start = 1'b0;
        safe();
        tick();
        Reset = 1'b0;
    endtask

    task automatic start_game();
        Start = 1'b1;
        tick();
        Start = 1'b0;
    endtask

    // Pipe1 goes right of the bird then fully left: one pass
    task automatic pass1();
        PipePosX1 = 10'd220;
        tick();
        PipePosX1 = 10'd139;
        tick();
    endtask

    initial begin
        vecs[0]  = mk("gap_clear",      200, 190, 150, 1000, 150, 1'b0, 16'h0000);
        vecs[1]  = mk("gap_top_hit",    200, 190, 250, 1000, 150, 1'b1, 16'h0000);
        vecs[2]  = mk("offscreen",      200, 1000, 250, 1000, 900, 1'b0, 16'h0000);
        vecs[3]  = mk("floor_450",      450, 1000, 150, 1000, 150, 1'b1, 16'h0000);
        vecs[4]  = mk("floor_449",      449, 1000, 150, 1000, 150, 1'b0, 16'h0000);
        vecs[5]  = mk("ceiling_0",      0,   1000, 150, 1000, 150, 1'b1, 16'h0000);
        vecs[6]  = mk("ceiling_1",      1,   1000, 150, 1000, 150, 1'b0, 16'h0000);
        vecs[7]  = mk("x_220_clear",    200, 220, 500, 1000, 150, 1'b0, 16'h0000);
        vecs[8]  = mk("x_219_hit",      200, 219, 500, 1000, 150, 1'b1, 16'h0000);
        vecs[9]  = mk("x_140_clear",    200, 140, 500, 1000, 150, 1'b0, 16'h0000);
        vecs[10] = mk("x_141_hit",      200, 141, 500, 1000, 150, 1'b1, 16'h0000);
        vecs[11] = mk("gap_bot_edge",   200, 190, 100, 1000, 150, 1'b0, 16'h0000);
        vecs[12] = mk("gap_bot_hit",    200, 190, 99,  1000, 150, 1'b1, 16'h0000);
        vecs[13] = mk("gap_top_edge",   200, 190, 200, 1000, 150, 1'b0, 16'h0000);
        vecs[14] = mk("gap_top_201",    200, 190, 201, 1000, 150, 1'b1, 16'h0000);
        vecs[15] = mk("pipe2_hit",      200, 1000, 150, 190, 250, 1'b1, 16'h0000);
        vecs[16] = mk("pass1",          200, 139, 500, 1000, 150, 1'b0, 16'h0001);
        vecs[17] = mk("pass_both",      200, 139, 500, 139,  500, 1'b0, 16'h0002);
        vecs[18] = mk("pass_and_hit",   0,   139, 500, 1000, 150, 1'b1, 16'h0001);

        Reset = 1'b1;
        Start = 1'b0;
        safe();
        tick();
        tick();
        Reset = 1'b0;

        // Reset state and first start
        chk("rst_playing", Playing, 1'b0);
        chk("rst_lost", Lost, 1'b0);
        chk("rst_score", Score, 16'h0000);
        chk("rst_high", HighScore, 16'h0000);
        start_game();
        chk("start_playing", Playing, 1'b1);
        chk("start_score", Score, 16'h0000);
        chk("start_lost", Lost, 1'b0);

        // Geometry table: one cycle of input from a fresh game
        for (int i = 0; i < NVEC; i++) begin
            do_reset();
            start_game();
            BirdPosY  = vecs[i].by;
            PipePosX1 = vecs[i].px1;
            PipePosY1 = vecs[i].py1;
            PipePosX2 = vecs[i].px2;
            PipePosY2 = vecs[i].py2;
            tick();
            safe();
            chk({vecs[i].name, "_lost"}, Lost, vecs[i].exp_lost);
            chk({vecs[i].name, "_playing"}, Playing, !vecs[i].exp_lost);
            chk({vecs[i].name, "_score"}, Score, vecs[i].exp_score);
        end

        // Stepping pass counts once; high score and Start-edge handling
        do_reset();
        start_game();
        PipePosY1 = 10'd150;
        PipePosX1 = 10'd141;
        tick();
        chk("step_141_lost", Lost, 1'b0);
        PipePosX1 = 10'd140;
        tick();
        chk("step_140_score", Score, 16'h0000);
        PipePosX1 = 10'd139;
        tick();
        chk("step_139_score", Score, 16'h0001);
        repeat (100) tick();
        chk("hold_139_score", Score, 16'h0001);
        chk("hold_139_lost", Lost, 1'b0);
        pass1();
        chk("second_pass", Score, 16'h0002);
        BirdPosY = 10'd450;
        tick();
        chk("floor_lost", Lost, 1'b1);
        chk("high_not_yet", HighScore, 16'h0000);
        tick();
        chk("high_loaded", HighScore, 16'h0002);
        pass1();
        chk("frozen_lost", Score, 16'h0002);
        Start = 1'b1;
        tick();
        chk("lost_to_idle_lost", Lost, 1'b0);
        chk("lost_to_idle_play", Playing, 1'b0);
        repeat (5) tick();
        chk("held_start_idle", Playing, 1'b0);
        chk("idle_score_frozen", Score, 16'h0002);
        Start = 1'b0;
        safe();
        tick();
        Start = 1'b1;
        tick();
        Start = 1'b0;
        chk("restart_playing", Playing, 1'b1);
        chk("restart_score", Score, 16'h0000);
        chk("restart_high", HighScore, 16'h0002);
        BirdPosY = 10'd0;
        tick();
        chk("low_game_lost", Lost, 1'b1);
        tick();
        tick();
        chk("high_kept", HighScore, 16'h0002);

        // Reset mid-PLAY and mid-LOST
        do_reset();
        start_game();
        repeat (5) pass1();
        chk("five_score", Score, 16'h0005);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        chk("rst_play_playing", Playing, 1'b0);
        chk("rst_play_score", Score, 16'h0000);
        chk("rst_play_high", HighScore, 16'h0000);
        safe();
        start_game();
        repeat (5) pass1();
        BirdPosY = 10'd0;
        tick();
        chk("rst_lost_entry", Lost, 1'b1);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        safe();
        chk("rst_lost_lost", Lost, 1'b0);
        chk("rst_lost_score", Score, 16'h0000);
        tick();
        chk("rst_lost_high", HighScore, 16'h0000);

        // Saturation: 4999 double passes reach 9998
        do_reset();
        start_game();
        for (int k = 0; k < 4999; k++) begin
            PipePosX1 = 10'd220;
            PipePosX2 = 10'd220;
            tick();
            PipePosX1 = 10'd139;
            PipePosX2 = 10'd139;
            tick();
            if (k == 49) chk("bcd_carry_100", Score, 16'h0100);
        end
        chk("preset_9998", Score, 16'h9998);
        PipePosX2 = 10'd1000;
        pass1();
        chk("sat_9999", Score, 16'h9999);
        pass1();
        chk("sat_hold", Score, 16'h9999);
        chk("sat_lost", Lost, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
